// File: rtl/radio_timing_engine_pkg.sv
`default_nettype none
// ============================================================================
// rte_pkg : shared state encoding, default widths and strobe encodings
// Revision: 1.0
// ============================================================================
package rte_pkg;

  localparam int RTE_CNT_W_DEF   = 16;
  localparam int RTE_RAMP_W_DEF  = 8;
  localparam int RTE_SLOT_W_DEF  = 8;
  localparam int RTE_GAP_CYC_DEF = 4;

  typedef enum logic [2:0] {
    RTE_IDLE     = 3'd0,
    RTE_WARMUP   = 3'd1,
    RTE_ACTIVE   = 3'd2,
    RTE_COOLDOWN = 3'd3,
    RTE_GAP      = 3'd4
  } rte_state_e;

  // {enable, rxEn} per state
  localparam logic [1:0] OUT_IDLE      = 2'b00;
  localparam logic [1:0] OUT_WARMUP    = 2'b10;
  localparam logic [1:0] OUT_ACTIVE_TX = 2'b10;
  localparam logic [1:0] OUT_ACTIVE_RX = 2'b11;
  localparam logic [1:0] OUT_COOLDOWN  = 2'b10;
  localparam logic [1:0] OUT_GAP       = 2'b00;

  function automatic logic [1:0] rte_out_enc(input rte_state_e st, input logic rx_mode);
    logic [1:0] enc;
    enc = OUT_IDLE;
    case (st)
      RTE_WARMUP:   enc = OUT_WARMUP;
      RTE_ACTIVE:   enc = rx_mode ? OUT_ACTIVE_RX : OUT_ACTIVE_TX;
      RTE_COOLDOWN: enc = OUT_COOLDOWN;
      RTE_GAP:      enc = OUT_GAP;
      default:      enc = OUT_IDLE;
    endcase
    return enc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/radio_timing_engine_if.sv
`default_nettype none
// ============================================================================
// radio_timing_engine_if : control inputs and strobe/status outputs
// Revision: 1.0
// ============================================================================
interface radio_timing_engine_if
  import rte_pkg::*;
#(
  parameter int CNT_W  = RTE_CNT_W_DEF,
  parameter int RAMP_W = RTE_RAMP_W_DEF,
  parameter int SLOT_W = RTE_SLOT_W_DEF
);

  logic              start;
  logic              abort;
  logic              rx_mode;
  logic [RAMP_W-1:0] warmup_cyc;
  logic [CNT_W-1:0]  active_cyc;
  logic [RAMP_W-1:0] cooldown_cyc;
  logic [SLOT_W-1:0] num_slots;
  logic              radio_enable_unsynced;
  logic              radio_rx_en_unsynced;
  logic              busy;
  logic              slot_done;
  logic              seq_done;
  logic              aborted;
  logic              cfg_err;

  modport master (
    output start, abort, rx_mode, warmup_cyc, active_cyc, cooldown_cyc, num_slots,
    input  radio_enable_unsynced, radio_rx_en_unsynced, busy, slot_done, seq_done,
           aborted, cfg_err
  );

  modport slave (
    input  start, abort, rx_mode, warmup_cyc, active_cyc, cooldown_cyc, num_slots,
    output radio_enable_unsynced, radio_rx_en_unsynced, busy, slot_done, seq_done,
           aborted, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/radio_timing_engine_down_counter.sv
`default_nettype none
// ============================================================================
// rte_down_counter : loadable down-counter with zero flag, holds at zero
// Revision: 1.0
// ============================================================================
module rte_down_counter #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         arst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/radio_timing_engine.sv
`default_nettype none
// ============================================================================
// radio_timing_engine : warm-up / active / cool-down / gap slot sequencer
//                       producing glitch-free radio enable strobes
// Revision: 1.0
// ============================================================================
module radio_timing_engine
  import rte_pkg::*;
#(
  parameter int CNT_W   = RTE_CNT_W_DEF,
  parameter int RAMP_W  = RTE_RAMP_W_DEF,
  parameter int SLOT_W  = RTE_SLOT_W_DEF,
  parameter int GAP_CYC = RTE_GAP_CYC_DEF
) (
  input  logic                 ck,
  input  logic                 arst_n,
  radio_timing_engine_if.slave bus
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  localparam logic [2:0] ST_IDLE     = RTE_IDLE;
  localparam logic [2:0] ST_WARMUP   = RTE_WARMUP;
  localparam logic [2:0] ST_ACTIVE   = RTE_ACTIVE;
  localparam logic [2:0] ST_COOLDOWN = RTE_COOLDOWN;
  localparam logic [2:0] ST_GAP      = RTE_GAP;

  logic [2:0]        state_d, state_q;
  logic              rx_mode_d, rx_mode_q;
  logic [RAMP_W-1:0] warmup_d, warmup_q;
  logic [CNT_W-1:0]  active_d, active_q;
  logic [RAMP_W-1:0] cooldown_d, cooldown_q;
  logic              abort_seen_d, abort_seen_q;
  logic              slot_cut_d, slot_cut_q;
  logic              enable_d, enable_q;
  logic              rx_en_d, rx_en_q;
  logic              busy_d, busy_q;
  logic              slot_done_d, slot_done_q;
  logic              seq_done_d, seq_done_q;
  logic              aborted_d, aborted_q;
  logic              cfg_err_d, cfg_err_q;

  logic              w_cut;
  logic              w_end_slot;
  logic              w_ramp_load, w_ramp_dec, w_ramp_zero;
  logic [RAMP_W-1:0] w_ramp_val;
  logic              w_act_load, w_act_dec, w_act_zero;
  logic [CNT_W-1:0]  w_act_val;
  logic              w_gap_load, w_gap_dec, w_gap_zero;
  logic              w_slot_load, w_slot_dec, w_slot_zero;
  logic [SLOT_W-1:0] w_slot_val;

  // Warm-up and cool-down never overlap, so they share one ramp counter.
  rte_down_counter #(.W(RAMP_W)) u_ramp_cnt (
    .ck(ck), .arst_n(arst_n), .i_load(w_ramp_load), .i_load_val(w_ramp_val),
    .i_dec(w_ramp_dec), .o_zero(w_ramp_zero)
  );

  rte_down_counter #(.W(CNT_W)) u_active_cnt (
    .ck(ck), .arst_n(arst_n), .i_load(w_act_load), .i_load_val(w_act_val),
    .i_dec(w_act_dec), .o_zero(w_act_zero)
  );

  rte_down_counter #(.W(GAP_W)) u_gap_cnt (
    .ck(ck), .arst_n(arst_n), .i_load(w_gap_load), .i_load_val(GAP_LOAD),
    .i_dec(w_gap_dec), .o_zero(w_gap_zero)
  );

  rte_down_counter #(.W(SLOT_W)) u_slot_cnt (
    .ck(ck), .arst_n(arst_n), .i_load(w_slot_load), .i_load_val(w_slot_val),
    .i_dec(w_slot_dec), .o_zero(w_slot_zero)
  );

  assign w_ramp_dec = (state_q == ST_WARMUP) || (state_q == ST_COOLDOWN);
  assign w_act_dec  = (state_q == ST_ACTIVE);
  assign w_gap_dec  = (state_q == ST_GAP);

  always_comb begin
    state_d      = state_q;
    rx_mode_d    = rx_mode_q;
    warmup_d     = warmup_q;
    active_d     = active_q;
    cooldown_d   = cooldown_q;
    abort_seen_d = abort_seen_q;
    slot_cut_d   = slot_cut_q;
    slot_done_d  = 1'b0;
    seq_done_d   = 1'b0;
    aborted_d    = 1'b0;
    cfg_err_d    = 1'b0;
    w_cut        = 1'b0;
    w_end_slot   = 1'b0;
    w_ramp_load  = 1'b0;
    w_ramp_val   = '0;
    w_act_load   = 1'b0;
    w_act_val    = '0;
    w_gap_load   = 1'b0;
    w_slot_load  = 1'b0;
    w_slot_val   = '0;
    w_slot_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          if ((bus.active_cyc == '0) || (bus.num_slots == '0)) begin
            cfg_err_d = 1'b1;
          end else begin
            rx_mode_d    = bus.rx_mode;
            warmup_d     = bus.warmup_cyc;
            active_d     = bus.active_cyc;
            cooldown_d   = bus.cooldown_cyc;
            abort_seen_d = 1'b0;
            slot_cut_d   = 1'b0;
            w_slot_load  = 1'b1;
            w_slot_val   = bus.num_slots - SLOT_W'(1);
            if (bus.warmup_cyc != '0) begin
              state_d     = ST_WARMUP;
              w_ramp_load = 1'b1;
              w_ramp_val  = bus.warmup_cyc - RAMP_W'(1);
            end else begin
              state_d    = ST_ACTIVE;
              w_act_load = 1'b1;
              w_act_val  = bus.active_cyc - CNT_W'(1);
            end
          end
        end
      end
      ST_WARMUP: begin
        if (bus.abort) begin
          w_cut = 1'b1;
        end else if (w_ramp_zero) begin
          state_d    = ST_ACTIVE;
          w_act_load = 1'b1;
          w_act_val  = active_q - CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (bus.abort) begin
          w_cut = 1'b1;
        end else if (w_act_zero) begin
          if (cooldown_q != '0) begin
            state_d     = ST_COOLDOWN;
            w_ramp_load = 1'b1;
            w_ramp_val  = cooldown_q - RAMP_W'(1);
          end else begin
            w_end_slot = 1'b1;
          end
        end
      end
      ST_COOLDOWN: begin
        if (bus.abort) begin
          abort_seen_d = 1'b1;
        end
        if (w_ramp_zero) begin
          w_end_slot = 1'b1;
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          state_d    = ST_IDLE;
          seq_done_d = 1'b1;
          aborted_d  = 1'b1;
        end else if (w_gap_zero) begin
          if (warmup_q != '0) begin
            state_d     = ST_WARMUP;
            w_ramp_load = 1'b1;
            w_ramp_val  = warmup_q - RAMP_W'(1);
          end else begin
            state_d    = ST_ACTIVE;
            w_act_load = 1'b1;
            w_act_val  = active_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort from warm-up/active: drop rxEn now, still ramp down, forget remaining slots.
    if (w_cut) begin
      abort_seen_d = 1'b1;
      slot_cut_d   = 1'b1;
      w_slot_load  = 1'b1;
      w_slot_val   = '0;
      if (cooldown_q != '0) begin
        state_d     = ST_COOLDOWN;
        w_ramp_load = 1'b1;
        w_ramp_val  = cooldown_q - RAMP_W'(1);
      end else begin
        state_d    = ST_IDLE;
        seq_done_d = 1'b1;
        aborted_d  = 1'b1;
      end
    end

    if (w_end_slot) begin
      slot_done_d = !slot_cut_q;
      if (w_slot_zero || abort_seen_q || bus.abort) begin
        state_d    = ST_IDLE;
        seq_done_d = 1'b1;
        aborted_d  = abort_seen_q || bus.abort;
      end else begin
        state_d    = ST_GAP;
        w_gap_load = 1'b1;
        w_slot_dec = 1'b1;
      end
    end

    // Strobes are decoded from the next state so they leave a flop directly.
    {enable_d, rx_en_d} = rte_out_enc(rte_state_e'(state_d), rx_mode_d);
    busy_d              = (state_d != ST_IDLE);
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      rx_mode_q    <= 1'b0;
      warmup_q     <= '0;
      active_q     <= '0;
      cooldown_q   <= '0;
      abort_seen_q <= 1'b0;
      slot_cut_q   <= 1'b0;
      enable_q     <= 1'b0;
      rx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      slot_done_q  <= 1'b0;
      seq_done_q   <= 1'b0;
      aborted_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_mode_q    <= rx_mode_d;
      warmup_q     <= warmup_d;
      active_q     <= active_d;
      cooldown_q   <= cooldown_d;
      abort_seen_q <= abort_seen_d;
      slot_cut_q   <= slot_cut_d;
      enable_q     <= enable_d;
      rx_en_q      <= rx_en_d;
      busy_q       <= busy_d;
      slot_done_q  <= slot_done_d;
      seq_done_q   <= seq_done_d;
      aborted_q    <= aborted_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.radio_enable_unsynced = enable_q;
  assign bus.radio_rx_en_unsynced  = rx_en_q;
  assign bus.busy                  = busy_q;
  assign bus.slot_done             = slot_done_q;
  assign bus.seq_done              = seq_done_q;
  assign bus.aborted               = aborted_q;
  assign bus.cfg_err               = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_radio_timing_engine.sv
`default_nettype none
// ============================================================================
// tb_radio_timing_engine : vector table, directed sequences and randomized
//                          slot programs checked against a timeline model
// Revision: 1.0
// ============================================================================
module tb_radio_timing_engine;

  localparam int CNT_W   = 16;
  localparam int RAMP_W  = 8;
  localparam int SLOT_W  = 8;
  localparam int GAP_CYC = 4;

  localparam int PH_I = 0;
  localparam int PH_W = 1;
  localparam int PH_A = 2;
  localparam int PH_C = 3;
  localparam int PH_G = 4;

  logic ck = 1'b0;
  logic arst_n = 1'b0;

  radio_timing_engine_if #(.CNT_W(CNT_W), .RAMP_W(RAMP_W), .SLOT_W(SLOT_W)) bus ();

  radio_timing_engine #(
    .CNT_W(CNT_W), .RAMP_W(RAMP_W), .SLOT_W(SLOT_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .ck(ck),
    .arst_n(arst_n),
    .bus(bus)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle expectation {busy, enable, rxEn, slot_done, seq_done, aborted, cfg_err}
  logic [6:0] exp_q[$];
  int         ph_q[$];

  typedef struct {
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  active;
    logic [SLOT_W-1:0] slots;
    logic              exp_cfg_err;
  } vec_t;

  function automatic logic [6:0] dut_out();
    return {bus.busy, bus.radio_enable_unsynced, bus.radio_rx_en_unsynced,
            bus.slot_done, bus.seq_done, bus.aborted, bus.cfg_err};
  endfunction

  function automatic void check(string name, int cyc, logic [6:0] act, logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got busy/en/rx/sd/qd/ab/ce=%b required %b",
                  name, cyc, act, exp);
  endfunction

  function automatic void emit(int ph, logic en, logic rx, logic sd, logic qd, logic ab);
    ph_q.push_back(ph);
    exp_q.push_back({(ph != PH_I), en, rx, sd, qd, ab, 1'b0});
  endfunction

  function automatic void trunc(int last);
    while (exp_q.size() > last + 1) begin
      void'(exp_q.pop_back());
      void'(ph_q.pop_back());
    end
  endfunction

  // Timeline of a start at cycle 0, with an optional one-cycle abort during cycle k.
  function automatic void build_model(int w, int a, int c, int n, logic rx, int k);
    exp_q.delete();
    ph_q.delete();
    emit(PH_I, 0, 0, 0, 0, 0);
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < w; i++) emit(PH_W, 1, 0, 0, 0, 0);
      for (int i = 0; i < a; i++) emit(PH_A, 1, rx, 0, 0, 0);
      for (int i = 0; i < c; i++) emit(PH_C, 1, 0, 0, 0, 0);
      if (s < n - 1) begin
        for (int g = 0; g < GAP_CYC; g++) emit(PH_G, 0, 0, (g == 0), 0, 0);
      end
    end
    emit(PH_I, 0, 0, 1, 1, 0);
    if (k >= 1 && k < ph_q.size()) begin
      int p;
      p = ph_q[k];
      if (p == PH_W || p == PH_A) begin
        trunc(k);
        for (int i = 0; i < c; i++) emit(PH_C, 1, 0, 0, 0, 0);
        emit(PH_I, 0, 0, 0, 1, 1);
      end else if (p == PH_C) begin
        int j;
        j = k;
        while (ph_q[j + 1] == PH_C) j++;
        trunc(j);
        emit(PH_I, 0, 0, 1, 1, 1);
      end else if (p == PH_G) begin
        trunc(k);
        emit(PH_I, 0, 0, 0, 1, 1);
      end
    end
  endfunction

  task automatic run_seq(string name, int w, int a, int c, int n, logic rx, int k, bit noisy);
    logic [6:0] exp;
    build_model(w, a, c, n, rx, k);
    @(negedge ck);
    bus.warmup_cyc   = RAMP_W'(w);
    bus.active_cyc   = CNT_W'(a);
    bus.cooldown_cyc = RAMP_W'(c);
    bus.num_slots    = SLOT_W'(n);
    bus.rx_mode      = rx;
    bus.abort        = 1'b0;
    bus.start        = 1'b1;
    for (int t = 1; t < exp_q.size() + 3; t++) begin
      @(negedge ck);
      exp = (t < exp_q.size()) ? exp_q[t] : 7'b0;
      check(name, t, dut_out(), exp);
      bus.start = 1'b0;
      bus.abort = (t == k);
      if (noisy && exp[6]) begin
        bus.start        = 1'($urandom_range(0, 1));
        bus.rx_mode      = 1'($urandom_range(0, 1));
        bus.warmup_cyc   = RAMP_W'($urandom_range(0, 255));
        bus.active_cyc   = CNT_W'($urandom_range(0, 65535));
        bus.cooldown_cyc = RAMP_W'($urandom_range(0, 255));
        bus.num_slots    = SLOT_W'($urandom_range(0, 255));
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.rx_mode      = 1'b0;
    bus.warmup_cyc   = '0;
    bus.active_cyc   = '0;
    bus.cooldown_cyc = '0;
    bus.num_slots    = '0;

    #12;
    check("reset_state", 0, dut_out(), 7'b0);
    @(negedge ck);
    arst_n = 1'b1;

    // IDLE-only requests: none of these may start a sequence.
    vecs[0] = '{start: 1'b1, abort: 1'b0, active: 16'd0, slots: 8'd3, exp_cfg_err: 1'b1};
    vecs[1] = '{start: 1'b1, abort: 1'b0, active: 16'd5, slots: 8'd0, exp_cfg_err: 1'b1};
    vecs[2] = '{start: 1'b1, abort: 1'b0, active: 16'd0, slots: 8'd0, exp_cfg_err: 1'b1};
    vecs[3] = '{start: 1'b1, abort: 1'b1, active: 16'd0, slots: 8'd3, exp_cfg_err: 1'b0};
    vecs[4] = '{start: 1'b1, abort: 1'b1, active: 16'd5, slots: 8'd3, exp_cfg_err: 1'b0};
    vecs[5] = '{start: 1'b0, abort: 1'b0, active: 16'd0, slots: 8'd0, exp_cfg_err: 1'b0};
    vecs[6] = '{start: 1'b0, abort: 1'b1, active: 16'd5, slots: 8'd3, exp_cfg_err: 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge ck);
      bus.start      = vecs[i].start;
      bus.abort      = vecs[i].abort;
      bus.active_cyc = vecs[i].active;
      bus.num_slots  = vecs[i].slots;
      bus.warmup_cyc = RAMP_W'(2);
      @(negedge ck);
      check($sformatf("vec%0d_resp", i), 1, dut_out(), {6'b0, vecs[i].exp_cfg_err});
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge ck);
      check($sformatf("vec%0d_after", i), 2, dut_out(), 7'b0);
    end

    run_seq("single_slot_rx", 3, 5, 2, 1, 1'b1, -1, 1'b0);
    run_seq("three_slot_rx", 0, 2, 0, 3, 1'b1, -1, 1'b0);
    run_seq("three_slot_tx", 0, 2, 0, 3, 1'b0, -1, 1'b0);
    run_seq("abort_active", 2, 10, 2, 1, 1'b1, 5, 1'b0);
    run_seq("abort_active_nocd", 0, 4, 0, 2, 1'b1, 2, 1'b0);
    run_seq("abort_gap", 1, 2, 1, 3, 1'b1, 6, 1'b0);
    run_seq("abort_cooldown", 1, 2, 3, 2, 1'b0, 5, 1'b0);
    run_seq("start_while_busy", 2, 3, 1, 2, 1'b1, -1, 1'b1);
    run_seq("slots_255", 0, 1, 0, 255, 1'b1, -1, 1'b0);

    // Asynchronous reset while ACTIVE
    @(negedge ck);
    bus.warmup_cyc   = '0;
    bus.active_cyc   = CNT_W'(10);
    bus.cooldown_cyc = '0;
    bus.num_slots    = SLOT_W'(1);
    bus.rx_mode      = 1'b1;
    bus.start        = 1'b1;
    @(negedge ck);
    bus.start = 1'b0;
    @(negedge ck);
    @(negedge ck);
    check("rst_pre", 3, dut_out(), 7'b1110000);
    #2 arst_n = 1'b0;
    #1 check("rst_async", 3, dut_out(), 7'b0);
    @(negedge ck);
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      check("rst_quiet", i, dut_out(), 7'b0);
    end
    run_seq("after_reset", 1, 3, 1, 2, 1'b1, -1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int w, a, c, n, k;
      logic rx;
      w  = $urandom_range(0, 4);
      a  = $urandom_range(1, 6);
      c  = $urandom_range(0, 3);
      n  = $urandom_range(1, 4);
      rx = 1'($urandom_range(0, 1));
      k  = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, n * (w + a + c + GAP_CYC) + 1);
      run_seq($sformatf("rand%0d", r), w, a, c, n, rx, k, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
